// File: rtl/lsu_ctrl.sv
// RV32I load/store unit controller: sequences loads, word stores and byte/half
// read-modify-write stores against a combinational-read, clocked-write data memory.
module lsu_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_write_enable,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RMW_READ,
      S_WRITE,
      S_RESP
   } state_t;

   state_t      r_state;
   logic        r_store;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic        r_resp_fault;
   logic [31:0] r_resp_rdata;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;

   logic        w_legal;
   logic        w_misaligned;
   logic        w_fault;
   logic [31:0] w_word_addr;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_val;
   logic [31:0] w_merged;

   // Decode of the incoming request, valid only while IDLE.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_legal      = 1'b0;
      w_misaligned = 1'b0;
      if (req_store)
         w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      else
         w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                   (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
      case (req_funct3[1:0])
         2'b01:   w_misaligned = req_addr[0];
         2'b10:   w_misaligned = |req_addr[1:0];
         default: w_misaligned = 1'b0;
      endcase
   end

   assign w_fault     = !w_legal || w_misaligned;
   assign w_word_addr = {req_addr[31:2], 2'b00};

   // Lane extraction for loads and lane merge for byte/half stores, from the latched request.
   always_comb begin
      w_byte = 8'h00;
      case (r_addr[1:0])
         2'b00: w_byte = mem_read_data[7:0];
         2'b01: w_byte = mem_read_data[15:8];
         2'b10: w_byte = mem_read_data[23:16];
         2'b11: w_byte = mem_read_data[31:24];
      endcase
      w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];

      w_load_val = mem_read_data;
      case (r_funct3)
         3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_val = {24'h000000, w_byte};
         3'b101:  w_load_val = {16'h0000, w_half};
         default: w_load_val = mem_read_data;
      endcase

      w_merged = mem_read_data;
      case (r_funct3)
         3'b000: begin
            case (r_addr[1:0])
               2'b00: w_merged[7:0]   = r_wdata[7:0];
               2'b01: w_merged[15:8]  = r_wdata[7:0];
               2'b10: w_merged[23:16] = r_wdata[7:0];
               2'b11: w_merged[31:24] = r_wdata[7:0];
            endcase
         end
         3'b001: begin
            if (r_addr[1])
               w_merged[31:16] = r_wdata[15:0];
            else
               w_merged[15:0]  = r_wdata[15:0];
         end
         default: w_merged = r_wdata;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_store      <= 1'b0;
         r_funct3     <= 3'b000;
         r_addr       <= 32'h0;
         r_wdata      <= 32'h0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_fault <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 32'h0;
         r_mem_wdata  <= 32'h0;
      end else begin
         r_resp_valid <= 1'b0;
         r_mem_we     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_store     <= req_store;
                  r_funct3    <= req_funct3;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (w_fault) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_fault <= 1'b1;
                     r_resp_rdata <= 32'h0;
                  end else if (!req_store) begin
                     r_state    <= S_LOAD;
                     r_mem_addr <= w_word_addr;
                  end else if (req_funct3 == 3'b010) begin
                     r_state     <= S_WRITE;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= w_word_addr;
                     r_mem_wdata <= req_wdata;
                  end else begin
                     r_state    <= S_RMW_READ;
                     r_mem_addr <= w_word_addr;
                  end
               end
            end
            S_LOAD: begin
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
               r_resp_fault <= 1'b0;
               r_resp_rdata <= r_store ? 32'h0 : w_load_val;
               r_mem_addr   <= 32'h0;
            end
            S_RMW_READ: begin
               r_state     <= S_WRITE;
               r_mem_we    <= 1'b1;
               r_mem_addr  <= {r_addr[31:2], 2'b00};
               r_mem_wdata <= w_merged;
            end
            S_WRITE: begin
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
               r_resp_fault <= 1'b0;
               r_resp_rdata <= 32'h0;
               r_mem_addr   <= 32'h0;
               r_mem_wdata  <= 32'h0;
            end
            S_RESP: begin
               r_state      <= S_IDLE;
               r_req_ready  <= 1'b1;
               r_resp_fault <= 1'b0;
               r_resp_rdata <= 32'h0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready        = r_req_ready;
   assign resp_valid       = r_resp_valid;
   assign resp_fault       = r_resp_fault;
   assign resp_rdata       = r_resp_rdata;
   assign mem_write_enable = r_mem_we;
   assign mem_addr         = r_mem_addr;
   assign mem_write_data   = r_mem_wdata;

endmodule
